// File: rtl/pipeline_stall_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipeline_stall_ctrl_if
//   Bundle of the stall/flush control signals between the pipeline (hazard
//   unit, EX-stage multiply detect, MEM-stage branch resolve) and the stall
//   controller.
//
//   Event inputs (driven by master, read by slave):
//     hazard_enable  load-use stall request, combinational, current cycle
//     mul_issue      multiply instruction valid in ID/EX this cycle
//     branch_taken   taken branch/jump resolved in MEM this cycle
//   Control outputs (driven by slave, read by master):
//     pc_write_en, if_id_write_en, if_id_flush, id_ex_write_en,
//     id_ex_bubble, ex_mem_bubble, mul_busy
//   Statistics (driven by slave):
//     stall_cycles [15:0], flush_count [7:0]
//
//   Signalling: there is no valid/ready pairing here. Every event input is a
//   level that is sampled once per rising clk edge; a request asserted in a
//   cycle is acted on in that same cycle (outputs are combinational) and its
//   side effects on state/counters land on the following edge. Nothing is
//   queued: a request that is lower priority than another in the same cycle,
//   or that arrives while it is ignored, is simply dropped.
// -----------------------------------------------------------------------------
interface pipeline_stall_ctrl_if;
    logic        hazard_enable;
    logic        mul_issue;
    logic        branch_taken;

    logic        pc_write_en;
    logic        if_id_write_en;
    logic        if_id_flush;
    logic        id_ex_write_en;
    logic        id_ex_bubble;
    logic        ex_mem_bubble;
    logic        mul_busy;

    logic [15:0] stall_cycles;
    logic [7:0]  flush_count;

    // Pipeline side: raises events, consumes control
    modport master (
        output hazard_enable,
        output mul_issue,
        output branch_taken,
        input  pc_write_en,
        input  if_id_write_en,
        input  if_id_flush,
        input  id_ex_write_en,
        input  id_ex_bubble,
        input  ex_mem_bubble,
        input  mul_busy,
        input  stall_cycles,
        input  flush_count
    );

    // Controller side
    modport slave (
        input  hazard_enable,
        input  mul_issue,
        input  branch_taken,
        output pc_write_en,
        output if_id_write_en,
        output if_id_flush,
        output id_ex_write_en,
        output id_ex_bubble,
        output ex_mem_bubble,
        output mul_busy,
        output stall_cycles,
        output flush_count
    );
endinterface

// File: rtl/pipeline_stall_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_stall_ctrl
//   Stall / flush controller for a 5-stage in-order pipeline. Arbitrates
//   between a taken branch (flush), a multi-cycle multiply in EX (freeze of
//   the front end) and a load-use hazard (one-cycle bubble into ID/EX).
//
//   Parameters:
//     MUL_LATENCY  total EX-stage cycles of a multiply, legal range 2..16.
//                  The front end is frozen MUL_LATENCY-1 cycles per multiply,
//                  the issue cycle included; the final EX cycle is the DONE
//                  state where the pipeline runs normally again.
//   Ports:
//     clk        single clock, rising edge
//     rst        synchronous, active-high reset
//     bus        pipeline_stall_ctrl_if.slave (events in, control/stats out)
//     state_dbg  registered FSM state (0 RUN, 1 MUL, 2 DONE)
//     cnt_dbg    registered multiply down-counter
// -----------------------------------------------------------------------------
module pipeline_stall_ctrl #(
    parameter int MUL_LATENCY = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    pipeline_stall_ctrl_if.slave        bus,
    output logic [1:0]                  state_dbg,
    output logic [3:0]                  cnt_dbg
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Count loaded on issue; MUL state runs until it reaches 1.
    localparam logic [3:0] CNT_LOAD = 4'(MUL_LATENCY - 2);
    // With MUL_LATENCY == 2 the only freeze is the issue cycle itself.
    localparam bit SKIP_MUL = (MUL_LATENCY <= 2);

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic [15:0] stall_cycles_q;
    logic [7:0]  flush_count_q;

    // One-hot action chosen this cycle
    logic        do_flush;
    logic        do_freeze;
    logic        do_load_use;

    // -------------------------------------------------------------------------
    // Next-state and action selection
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        do_flush    = 1'b0;
        do_freeze   = 1'b0;
        do_load_use = 1'b0;

        // During reset no action is taken, so outputs fall to the defaults
        // and the counters see no increment request.
        if (!rst) begin
            case (state)
                ST_RUN: begin
                    if (bus.branch_taken) begin
                        do_flush = 1'b1;
                    end else if (bus.mul_issue) begin
                        do_freeze = 1'b1;
                        cnt_nxt   = CNT_LOAD;
                        state_nxt = SKIP_MUL ? ST_DONE : ST_MUL;
                    end else if (bus.hazard_enable) begin
                        do_load_use = 1'b1;
                    end
                end

                ST_MUL: begin
                    // Multiply owns EX: nothing may disturb the freeze,
                    // a branch cannot be resolving in MEM behind a bubble.
                    do_freeze = 1'b1;
                    if (cnt <= 4'd1) begin
                        state_nxt = ST_DONE;
                    end else begin
                        cnt_nxt = cnt - 4'd1;
                    end
                end

                ST_DONE: begin
                    // Final multiply cycle: the result leaves EX this edge,
                    // so mul_issue still reflects the old multiply and is
                    // not a new request.
                    state_nxt = ST_RUN;
                    if (bus.branch_taken) begin
                        do_flush = 1'b1;
                    end else if (bus.hazard_enable) begin
                        do_load_use = 1'b1;
                    end
                end

                default: begin
                    state_nxt = ST_RUN;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Control outputs, combinational from the chosen action
    // -------------------------------------------------------------------------
    always_comb begin
        bus.pc_write_en    = 1'b1;
        bus.if_id_write_en = 1'b1;
        bus.if_id_flush    = 1'b0;
        bus.id_ex_write_en = 1'b1;
        bus.id_ex_bubble   = 1'b0;
        bus.ex_mem_bubble  = 1'b0;
        bus.mul_busy       = 1'b0;

        if (do_flush) begin
            // PC keeps writing so the branch target is fetched.
            bus.if_id_flush   = 1'b1;
            bus.id_ex_bubble  = 1'b1;
            bus.ex_mem_bubble = 1'b1;
        end else if (do_freeze) begin
            bus.pc_write_en    = 1'b0;
            bus.if_id_write_en = 1'b0;
            bus.id_ex_write_en = 1'b0;
            bus.ex_mem_bubble  = 1'b1;
            bus.mul_busy       = 1'b1;
        end else if (do_load_use) begin
            // Hold PC and IF/ID, let ID/EX capture a NOP.
            bus.pc_write_en    = 1'b0;
            bus.if_id_write_en = 1'b0;
            bus.id_ex_bubble   = 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // State register and saturating statistics
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_RUN;
            cnt            <= 4'd0;
            stall_cycles_q <= 16'd0;
            flush_count_q  <= 8'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if ((do_freeze || do_load_use) && (stall_cycles_q != 16'hFFFF)) begin
                stall_cycles_q <= stall_cycles_q + 16'd1;
            end
            if (do_flush && (flush_count_q != 8'hFF)) begin
                flush_count_q <= flush_count_q + 8'd1;
            end
        end
    end

    assign bus.stall_cycles = stall_cycles_q;
    assign bus.flush_count  = flush_count_q;
    assign state_dbg        = state;
    assign cnt_dbg          = cnt;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_stall_ctrl
//   Directed bench for pipeline_stall_ctrl. Instance A uses MUL_LATENCY=4,
//   instance B uses MUL_LATENCY=2. Control outputs are compared as a packed
//   vector {pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_bubble,
//   ex_mem_bubble, mul_busy}.
// -----------------------------------------------------------------------------
module tb_pipeline_stall_ctrl;

    localparam logic [6:0] CTL_DEF   = 7'b1101000;
    localparam logic [6:0] CTL_FRZ   = 7'b0000011;
    localparam logic [6:0] CTL_FLUSH = 7'b1111110;
    localparam logic [6:0] CTL_LU    = 7'b0001100;

    localparam logic [1:0] S_RUN  = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // ---------------------------------------------------------------- clock/reset
    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    pipeline_stall_ctrl_if if_a ();
    pipeline_stall_ctrl_if if_b ();

    logic [1:0] state_a, state_b;
    logic [3:0] cnt_a, cnt_b;

    pipeline_stall_ctrl #(.MUL_LATENCY(4)) dut_a (
        .clk       (clk),
        .rst       (rst),
        .bus       (if_a.slave),
        .state_dbg (state_a),
        .cnt_dbg   (cnt_a)
    );

    pipeline_stall_ctrl #(.MUL_LATENCY(2)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .bus       (if_b.slave),
        .state_dbg (state_b),
        .cnt_dbg   (cnt_b)
    );

    wire [6:0] ctl_a = {if_a.pc_write_en, if_a.if_id_write_en, if_a.if_id_flush,
                        if_a.id_ex_write_en, if_a.id_ex_bubble, if_a.ex_mem_bubble,
                        if_a.mul_busy};
    wire [6:0] ctl_b = {if_b.pc_write_en, if_b.if_id_write_en, if_b.if_id_flush,
                        if_b.id_ex_write_en, if_b.id_ex_bubble, if_b.ex_mem_bubble,
                        if_b.mul_busy};

    // ---------------------------------------------------------------- scoreboard
    int checks = 0;
    int errors = 0;
    logic [6:0] exp_q[$];
    logic [1:0] exp_st_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------------------------------------------------------- drivers
    // All driving happens 1 time unit after a rising edge; checks of
    // combinational outputs follow a further #1.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic h, input logic m, input logic b);
        if_a.hazard_enable = h;
        if_a.mul_issue     = m;
        if_a.branch_taken  = b;
        #1;
    endtask

    task automatic drive_b(input logic h, input logic m, input logic b);
        if_b.hazard_enable = h;
        if_b.mul_issue     = m;
        if_b.branch_taken  = b;
        #1;
    endtask

    task automatic reset_all();
        rst = 1'b1;
        drive_a(1'b0, 1'b0, 1'b0);
        drive_b(1'b0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
    endtask

    // ---------------------------------------------------------------- stimulus
    initial begin
        // Reset with every event input asserted: outputs must stay default.
        rst = 1'b1;
        drive_a(1'b1, 1'b1, 1'b1);
        drive_b(1'b1, 1'b1, 1'b1);
        check("rst_ctl_a", 32'(ctl_a), 32'(CTL_DEF));
        check("rst_ctl_b", 32'(ctl_b), 32'(CTL_DEF));
        tick();
        tick();
        check("rst_ctl_a_hold", 32'(ctl_a), 32'(CTL_DEF));
        check("rst_state_a", 32'(state_a), 32'(S_RUN));
        check("rst_cnt_a", 32'(cnt_a), 32'd0);
        check("rst_stall_a", 32'(if_a.stall_cycles), 32'd0);
        check("rst_flush_a", 32'(if_a.flush_count), 32'd0);

        // Multiply held 4 cycles: 3 freeze cycles, then DONE with defaults.
        reset_all();
        exp_q.push_back(CTL_FRZ); exp_st_q.push_back(S_MUL);
        exp_q.push_back(CTL_FRZ); exp_st_q.push_back(S_MUL);
        exp_q.push_back(CTL_FRZ); exp_st_q.push_back(S_DONE);
        exp_q.push_back(CTL_DEF); exp_st_q.push_back(S_RUN);
        for (int i = 0; i < 4; i++) begin
            drive_a(1'b0, 1'b1, 1'b0);
            check($sformatf("mul4_ctl%0d", i), 32'(ctl_a), 32'(exp_q.pop_front()));
            tick();
            check($sformatf("mul4_state%0d", i), 32'(state_a), 32'(exp_st_q.pop_front()));
        end
        drive_a(1'b0, 1'b0, 1'b0);
        check("mul4_stall", 32'(if_a.stall_cycles), 32'd3);
        check("mul4_flush", 32'(if_a.flush_count), 32'd0);

        // Single load-use cycle.
        reset_all();
        drive_a(1'b1, 1'b0, 1'b0);
        check("lu_ctl", 32'(ctl_a), 32'(CTL_LU));
        tick();
        drive_a(1'b0, 1'b0, 1'b0);
        check("lu_stall", 32'(if_a.stall_cycles), 32'd1);
        check("lu_after_ctl", 32'(ctl_a), 32'(CTL_DEF));

        // Branch beats multiply and hazard in RUN.
        reset_all();
        drive_a(1'b1, 1'b1, 1'b1);
        check("prio_ctl", 32'(ctl_a), 32'(CTL_FLUSH));
        tick();
        drive_a(1'b0, 1'b0, 1'b0);
        check("prio_state", 32'(state_a), 32'(S_RUN));
        check("prio_flush", 32'(if_a.flush_count), 32'd1);
        check("prio_stall", 32'(if_a.stall_cycles), 32'd0);

        // DONE handling, back-to-back multiply, branch ignored in MUL.
        reset_all();
        for (int i = 0; i < 3; i++) begin
            drive_a(1'b0, 1'b1, 1'b0);
            tick();
        end
        check("done_state", 32'(state_a), 32'(S_DONE));
        drive_a(1'b1, 1'b1, 1'b0);
        check("done_lu_ctl", 32'(ctl_a), 32'(CTL_LU));
        tick();
        check("done_to_run", 32'(state_a), 32'(S_RUN));
        drive_a(1'b0, 1'b1, 1'b0);
        check("b2b_ctl", 32'(ctl_a), 32'(CTL_FRZ));
        tick();
        check("b2b_state", 32'(state_a), 32'(S_MUL));
        check("b2b_cnt", 32'(cnt_a), 32'd2);
        drive_a(1'b1, 1'b0, 1'b1);
        check("mul_ign_br_ctl", 32'(ctl_a), 32'(CTL_FRZ));
        tick();
        check("mul_ign_br_flush", 32'(if_a.flush_count), 32'd0);
        check("mul_cnt_dec", 32'(cnt_a), 32'd1);
        drive_a(1'b0, 1'b0, 1'b0);
        check("mul_last_ctl", 32'(ctl_a), 32'(CTL_FRZ));
        tick();
        check("done2_state", 32'(state_a), 32'(S_DONE));
        drive_a(1'b1, 1'b1, 1'b1);
        check("done_flush_ctl", 32'(ctl_a), 32'(CTL_FLUSH));
        tick();
        drive_a(1'b0, 1'b0, 1'b0);
        check("done_flush_state", 32'(state_a), 32'(S_RUN));
        check("done_flush_cnt", 32'(if_a.flush_count), 32'd1);
        check("done_stall", 32'(if_a.stall_cycles), 32'd7);

        // Reset during the second MUL cycle.
        reset_all();
        drive_a(1'b0, 1'b1, 1'b0);
        tick();
        tick();
        check("midmul_state", 32'(state_a), 32'(S_MUL));
        check("midmul_cnt", 32'(cnt_a), 32'd1);
        rst = 1'b1;
        drive_a(1'b1, 1'b1, 1'b1);
        check("midmul_rst_ctl", 32'(ctl_a), 32'(CTL_DEF));
        tick();
        rst = 1'b0;
        drive_a(1'b0, 1'b0, 1'b0);
        check("midmul_rst_state", 32'(state_a), 32'(S_RUN));
        check("midmul_rst_cnt", 32'(cnt_a), 32'd0);
        check("midmul_rst_stall", 32'(if_a.stall_cycles), 32'd0);
        check("midmul_rst_busy", 32'(if_a.mul_busy), 32'd0);

        // MUL_LATENCY=2: one freeze, then DONE, then RUN.
        reset_all();
        drive_b(1'b0, 1'b1, 1'b0);
        check("l2_ctl0", 32'(ctl_b), 32'(CTL_FRZ));
        tick();
        check("l2_state0", 32'(state_b), 32'(S_DONE));
        check("l2_ctl1", 32'(ctl_b), 32'(CTL_DEF));
        tick();
        drive_b(1'b0, 1'b0, 1'b0);
        check("l2_state1", 32'(state_b), 32'(S_RUN));
        check("l2_stall", 32'(if_b.stall_cycles), 32'd1);

        // 300 load-use cycles.
        reset_all();
        for (int i = 0; i < 300; i++) begin
            drive_b(1'b1, 1'b0, 1'b0);
            tick();
        end
        drive_b(1'b0, 1'b0, 1'b0);
        check("lu300_stall", 32'(if_b.stall_cycles), 32'd300);
        check("lu300_flush", 32'(if_b.flush_count), 32'd0);

        // 260 flushes saturate at 255.
        reset_all();
        for (int i = 0; i < 260; i++) begin
            drive_b(1'b0, 1'b0, 1'b1);
            tick();
            if (i == 254) check("fl_reach_ff", 32'(if_b.flush_count), 32'hFF);
        end
        drive_b(1'b0, 1'b0, 1'b0);
        check("fl260_sat", 32'(if_b.flush_count), 32'hFF);
        check("fl260_stall", 32'(if_b.stall_cycles), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
